// File: rtl/mic1_microsequencer_pkg.sv
// Shared Mic-1 microinstruction layout, sequencer state encoding and width helper.
package mic1_pkg;

  localparam int CTRL_BITS = 27;

  localparam int NEXT_LSB = 27;
  localparam int JAM_MSB  = 26;
  localparam int JAM_LSB  = 24;
  localparam int ALU_MSB  = 23;
  localparam int ALU_LSB  = 16;
  localparam int C_MSB    = 15;
  localparam int C_LSB    = 7;
  localparam int MEM_MSB  = 6;
  localparam int MEM_LSB  = 4;
  localparam int B_MSB    = 3;
  localparam int B_LSB    = 0;

  // Bit positions inside the 3-bit JAM field
  localparam int JAM_JMPC = 2;
  localparam int JAM_JAMN = 1;
  localparam int JAM_JAMZ = 0;

  // Absolute bit positions of the MEM controls inside a microinstruction
  localparam int MEM_WRITE = 6;
  localparam int MEM_READ  = 5;
  localparam int MEM_FETCH = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

  function automatic int word_w(input int addr_w);
    return addr_w + CTRL_BITS;
  endfunction

endpackage

// File: rtl/mic1_microsequencer_if.sv
// Bundle between the Mic-1 sequencer, its control store and the datapath.
interface mic1_microsequencer_if #(
  parameter int ADDR_W = 9,
  parameter int MBR_W  = 8,
  parameter int CNT_W  = 32
);
  localparam int WORD_W = mic1_pkg::word_w(ADDR_W);

  logic [ADDR_W-1:0] ctrl_addr;
  logic [WORD_W-1:0] ctrl_data;
  logic [MBR_W-1:0]  mbr;
  logic              alu_n;
  logic              alu_z;
  logic              mem_busy;
  logic [WORD_W-1:0] mir;
  logic              mir_valid;
  logic              halted;
  logic [CNT_W-1:0]  ucount;

  modport master (
    output ctrl_addr, mir, mir_valid, halted, ucount,
    input  ctrl_data, mbr, alu_n, alu_z, mem_busy
  );

  modport slave (
    input  ctrl_addr, mir, mir_valid, halted, ucount,
    output ctrl_data, mbr, alu_n, alu_z, mem_busy
  );

endinterface

// File: rtl/mic1_microsequencer_next_addr.sv
// Combinational next-address formation: NEXT_ADDRESS OR-ed with JAMN/JAMZ high bit and JMPC MBR byte.
module mic1_next_addr
  import mic1_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int MBR_W  = 8
) (
  input  logic [ADDR_W-1:0] next_address,
  input  logic [2:0]        jam,
  input  logic              n,
  input  logic              z,
  input  logic [MBR_W-1:0]  mbr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              jam_zero
);

  logic [ADDR_W-1:0] mbr_ext;
  logic              hi_bit;

  always_comb begin
    mbr_ext = '0;
    if (jam[JAM_JMPC]) begin
      mbr_ext[MBR_W-1:0] = mbr;
    end
    hi_bit    = (jam[JAM_JAMN] & n) | (jam[JAM_JAMZ] & z);
    next_addr = next_address | mbr_ext;
    next_addr[ADDR_W-1] = next_addr[ADDR_W-1] | hi_bit;
  end

  assign jam_zero = (jam == 3'b000);

endmodule

// File: rtl/mic1_microsequencer.sv
// Mic-1 control unit: MPC/MIR registers, fetch/execute/stall FSM and committed-microinstruction counter.
module mic1_microsequencer
  import mic1_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int MBR_W      = 8,
  parameter int RESET_ADDR = 0,
  parameter int PIPELINED  = 0,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mic1_microsequencer_if.master bus
);

  localparam int                WORD_W  = word_w(ADDR_W);
  localparam logic [ADDR_W-1:0] RST_MPC = ADDR_W'(RESET_ADDR);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mpc_q, mpc_d;
  logic [WORD_W-1:0] mir_q, mir_d;
  logic              n_q, n_d;
  logic              z_q, z_d;
  logic              mir_valid_q, mir_valid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  ucount_q, ucount_d;

  logic [ADDR_W-1:0] ctrl_addr_c;
  logic [ADDR_W-1:0] next_addr;
  logic              jam_zero;
  logic              flag_n;
  logic              flag_z;
  logic              halt_hit;

  // EXEC branches on the live ALU flags; a WAIT exit uses the flags latched during EXEC.
  assign flag_n = (state_q == ST_EXEC) ? bus.alu_n : n_q;
  assign flag_z = (state_q == ST_EXEC) ? bus.alu_z : z_q;

  mic1_next_addr #(
    .ADDR_W (ADDR_W),
    .MBR_W  (MBR_W)
  ) u_next_addr (
    .next_address (mir_q[WORD_W-1:NEXT_LSB]),
    .jam          (mir_q[JAM_MSB:JAM_LSB]),
    .n            (flag_n),
    .z            (flag_z),
    .mbr          (bus.mbr),
    .next_addr    (next_addr),
    .jam_zero     (jam_zero)
  );

  assign halt_hit = jam_zero && (next_addr == mpc_q);

  always_comb begin
    state_d     = state_q;
    mpc_d       = mpc_q;
    mir_d       = mir_q;
    n_d         = n_q;
    z_d         = z_q;
    mir_valid_d = mir_valid_q;
    halted_d    = halted_q;
    ucount_d    = ucount_q;
    ctrl_addr_c = mpc_q;

    unique case (state_q)
      ST_LOAD: begin
        mir_d       = bus.ctrl_data;
        mir_valid_d = 1'b1;
        state_d     = ST_EXEC;
      end
      ST_EXEC, ST_WAIT: begin
        if (state_q == ST_EXEC) begin
          n_d      = bus.alu_n;
          z_d      = bus.alu_z;
          ucount_d = ucount_q + CNT_ONE;
        end
        if (bus.mem_busy) begin
          state_d     = ST_WAIT;
          mir_valid_d = 1'b0;
        end else if (halt_hit) begin
          state_d     = ST_HALT;
          halted_d    = 1'b1;
          mir_valid_d = 1'b0;
        end else begin
          mpc_d = next_addr;
          if (PIPELINED != 0) begin
            // Overlap the fetch of the successor with the commit of the current word.
            ctrl_addr_c = next_addr;
            mir_d       = bus.ctrl_data;
            state_d     = ST_EXEC;
            mir_valid_d = 1'b1;
          end else begin
            state_d     = ST_LOAD;
            mir_valid_d = 1'b0;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      mpc_q       <= RST_MPC;
      mir_q       <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      mir_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      ucount_q    <= '0;
    end else begin
      state_q     <= state_d;
      mpc_q       <= mpc_d;
      mir_q       <= mir_d;
      n_q         <= n_d;
      z_q         <= z_d;
      mir_valid_q <= mir_valid_d;
      halted_q    <= halted_d;
      ucount_q    <= ucount_d;
    end
  end

  assign bus.ctrl_addr = ctrl_addr_c;
  assign bus.mir       = mir_q;
  assign bus.mir_valid = mir_valid_q;
  assign bus.halted    = halted_q;
  assign bus.ucount    = ucount_q;

endmodule
